// File: rtl/dram_xfer_resp.sv
// Transfer responder: loads one frame from the host stream into image memory on
// rd_en, and streams the whole memory back to the host on wr_en.
module dram_xfer_resp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int WORDS  = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  output logic              rd_done,
  output logic              wr_done,
  output logic              busy,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LOAD, LOAD_FLUSH, LOAD_DONE, UNL_RD, UNL_WAIT, UNL_OUT, UNL_DONE
  } state_t;

  // Last address of a transfer; equals all ones when WORDS fills the address space.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state_r;
  logic [ADDR_W-1:0] cnt_r;

  assign in_ready = (state_r == LOAD);

  // Transfer FSM with all memory, stream and status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rd_en) begin
            state_r <= LOAD;
            cnt_r   <= '0;
            busy    <= 1'b1;
          end else if (wr_en) begin
            state_r  <= UNL_RD;
            cnt_r    <= '0;
            busy     <= 1'b1;
            mem_re   <= 1'b1;
            mem_addr <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (in_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt_r;
            mem_wdata <= in_data;
            // Hold the counter at the last address so it never wraps.
            if (cnt_r == LAST) begin
              state_r <= LOAD_FLUSH;
            end else begin
              cnt_r <= cnt_r + ONE;
            end
          end
        end
        LOAD_FLUSH: begin
          state_r <= LOAD_DONE;
          rd_done <= 1'b1;
        end
        LOAD_DONE: begin
          if (!rd_en) begin
            state_r <= IDLE;
            rd_done <= 1'b0;
            busy    <= 1'b0;
          end
        end
        UNL_RD: begin
          state_r <= UNL_WAIT;
        end
        UNL_WAIT: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
          state_r   <= UNL_OUT;
        end
        UNL_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt_r == LAST) begin
              state_r <= UNL_DONE;
              wr_done <= 1'b1;
            end else begin
              cnt_r    <= cnt_r + ONE;
              mem_re   <= 1'b1;
              mem_addr <= cnt_r + ONE;
              state_r  <= UNL_RD;
            end
          end
        end
        UNL_DONE: begin
          if (!wr_en) begin
            state_r <= IDLE;
            wr_done <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          rd_done   <= 1'b0;
          wr_done   <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_xfer_resp.sv
// Directed bench for dram_xfer_resp with a 4-word address space and a small memory model.
module tb_dram_xfer_resp;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd_en = 1'b0, wr_en = 1'b0;
  logic       rd_done, wr_done, busy;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready = 1'b0;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata = 8'h00;
  logic       mem_we, mem_re;

  int total = 0;
  int bad = 0;
  logic [7:0] mem [4];
  logic [1:0] waddr_q [$];
  logic [7:0] wdata_q [$];
  bit         overlap = 1'b0;

  dram_xfer_resp #(.DATA_W(8), .ADDR_W(2), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en),
    .rd_done(rd_done), .wr_done(wr_done), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we && mem_re) overlap = 1'b1;
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      waddr_q.push_back(mem_addr);
      wdata_q.push_back(mem_wdata);
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    total++; if ({rd_done, wr_done, busy, in_ready, out_valid, mem_we, mem_re, mem_addr, mem_wdata, out_data} !== 31'd0) begin bad++; $display("FAIL reset_outputs got=%0h want=0", {rd_done, wr_done, busy, in_ready, out_valid, mem_we, mem_re, mem_addr, mem_wdata, out_data}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load(input logic [7:0] base, input bit gap);
    waddr_q.delete();
    wdata_q.delete();
    rd_en = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%0b want=1", in_ready); end
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      tick();
      if (gap && i == 1) begin
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick();
          total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL gap_we cycle=%0d got=%0b want=0", j, mem_we); end
        end
      end
    end
    in_valid = 1'b0;
    total++; if ({mem_we, mem_addr, in_ready, rd_done} !== 5'b1_11_0_0) begin bad++; $display("FAIL flush_state got=%b want=11100", {mem_we, mem_addr, in_ready, rd_done}); end
    tick();
    total++; if ({rd_done, mem_we} !== 2'b10) begin bad++; $display("FAIL rd_done_rise got=%b want=10", {rd_done, mem_we}); end
    total++; if (waddr_q.size() !== 4) begin bad++; $display("FAIL write_count got=%0d want=4", waddr_q.size()); end
    for (int i = 0; i < 4 && i < waddr_q.size(); i++) begin
      total++; if ({waddr_q[i], wdata_q[i]} !== {2'(i), base + 8'(i)}) begin bad++; $display("FAIL write_%0d got=%0h/%0h want=%0h/%0h", i, waddr_q[i], wdata_q[i], i, base + 8'(i)); end
    end
    tick();
    total++; if ({rd_done, busy} !== 2'b00) begin bad++; $display("FAIL load_idle got=%b want=00", {rd_done, busy}); end
  endtask

  task automatic test_unload_backpressure();
    int n;
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    wr_en = 1'b1;
    out_ready = 1'b0;
    tick();
    total++; if ({mem_re, mem_addr} !== 3'b1_00) begin bad++; $display("FAIL unl_first_re got=%b want=100", {mem_re, mem_addr}); end
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL unl_valid_timeout word=%0d got=%0b want=1", i, out_valid); end
      if (i == 0) begin
        total++; if (n !== 2) begin bad++; $display("FAIL unl_latency got=%0d want=2", n); end
      end
      total++; if (out_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL unl_data_%0d got=%0h want=%0h", i, out_data, 8'h10 + 8'(i)); end
      total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL unl_early_done got=%0b want=0", wr_done); end
      if (i == 1) begin
        for (int j = 0; j < 2; j++) begin
          tick();
          total++; if ({out_valid, out_data} !== {1'b1, 8'h11}) begin bad++; $display("FAIL unl_hold got=%0h want=111", {out_valid, out_data}); end
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    total++; if ({wr_done, out_valid} !== 2'b10) begin bad++; $display("FAIL wr_done_rise got=%b want=10", {wr_done, out_valid}); end
    wr_en = 1'b0;
    tick();
    total++; if ({wr_done, busy} !== 2'b00) begin bad++; $display("FAIL unl_idle got=%b want=00", {wr_done, busy}); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got [$];
    int n;
    wr_en = 1'b1;
    test_load(8'hC0, 1'b0);
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL sim_wr_done got=%0b want=0", wr_done); end
    tick();
    total++; if ({mem_re, mem_addr, busy} !== 4'b1_00_1) begin bad++; $display("FAIL sim_unl_start got=%b want=1001", {mem_re, mem_addr, busy}); end
    out_ready = 1'b1;
    n = 0;
    while (!wr_done && n < 40) begin
      if (out_valid) got.push_back(out_data);
      tick();
      n++;
    end
    out_ready = 1'b0;
    total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL sim_done_timeout got=%0b want=1", wr_done); end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL sim_count got=%0d want=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL sim_data_%0d got=%0h want=%0h", i, got[i], 8'hC0 + 8'(i)); end
    end
    wr_en = 1'b0;
    tick();
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL sim_idle got=%0b want=0", wr_done); end
  endtask

  task automatic test_reset_mid_load();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h90 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if ({rd_done, wr_done, busy, in_ready, out_valid, mem_we, mem_re, mem_addr, mem_wdata, out_data} !== 31'd0) begin bad++; $display("FAIL midload_reset got=%0h want=0", {rd_done, wr_done, busy, in_ready, out_valid, mem_we, mem_re, mem_addr, mem_wdata, out_data}); end
    tick();
    reset = 1'b1;
    tick();
    test_load(8'h50, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load(8'hA0, 1'b0);
    test_unload_backpressure();
    test_simultaneous();
    test_load(8'h30, 1'b1);
    test_reset_mid_load();
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL we_re_overlap got=%0b want=0", overlap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_xfer_resp.md
# dram_xfer_resp

Responder side of the `rd_en`/`rd_done` and `wr_en`/`wr_done` transfer handshake issued by `state_control`. On a read request it fills the image memory with one full frame streamed in from the host. On a write request it streams the whole memory back out to the host. It sits between `state_control`, the image memory port and the external host byte stream in the downsampling system.

## Interface
- `DATA_W`, 8: word width of the stream and memory.
- `ADDR_W`, 16: memory address width.
- `WORDS`, 65536: words per transfer; must satisfy 1 ≤ WORDS ≤ 2^ADDR_W.

- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rd_en` in 1: level request, load host → memory.
- `wr_en` in 1: level request, unload memory → host.
- `rd_done` out 1: load complete. Held until `rd_en` is sampled low.
- `wr_done` out 1: unload complete. Held until `wr_en` is sampled low.
- `busy` out 1: high in every state except IDLE.
- `in_data` in DATA_W, `in_valid` in 1, `in_ready` out 1: host input stream.
- `out_data` out DATA_W, `out_valid` out 1, `out_ready` in 1: host output stream.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1, `mem_re` out 1: memory request, all registered.
- `mem_rdata` in DATA_W: valid in the cycle after `mem_re` is high.

## Operation
- States: IDLE, LOAD, LOAD_FLUSH, LOAD_DONE, UNL_RD, UNL_WAIT, UNL_OUT, UNL_DONE.
- Address counter `cnt` (ADDR_W bits) is cleared on every exit from IDLE.
- IDLE:
  - `rd_en`=1 → LOAD.
  - else `wr_en`=1 → UNL_RD.
  - Both high → `rd_en` wins.
- LOAD:
  - `in_ready`=1 (combinational from state).
  - On each `in_valid`&`in_ready`, the next edge registers `mem_we`=1, `mem_addr`=`cnt`, `mem_wdata`=`in_data`, and increments `cnt`.
  - Accepting word WORDS-1 → LOAD_FLUSH.
- LOAD_FLUSH:
  - `in_ready`=0.
  - The final write strobe is presented this cycle.
  - → LOAD_DONE.
- LOAD_DONE:
  - `rd_done`=1.
  - `rd_en` sampled low → IDLE.
- UNL_RD:
  - Registers `mem_re`=1, `mem_addr`=`cnt` for one cycle.
  - → UNL_WAIT.
- UNL_WAIT:
  - Captures `mem_rdata` into the `out_data` register.
  - → UNL_OUT.
- UNL_OUT:
  - `out_valid`=1; `out_data` stays stable until the handshake.
  - On `out_ready`: if `cnt`=WORDS-1 → UNL_DONE; else increment `cnt` → UNL_RD.
- UNL_DONE:
  - `wr_done`=1.
  - `wr_en` sampled low → IDLE.
- Requests that drop mid-transfer are ignored; the transfer always runs to completion.
- A new request seen while a done flag is high is ignored until IDLE is re-entered.
- `mem_we` and `mem_re` are never high in the same cycle.
- `mem_we` is high only for the single cycle following each accepted input word.
- `cnt` comparisons use the full ADDR_W width.
- WORDS = 2^ADDR_W: the last address is all ones, and the counter is never incremented past it.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE and `cnt`=0.
  - `rd_done`, `wr_done`, `busy`, `in_ready`, `out_valid`, `mem_we`, `mem_re` = 0.
  - `mem_addr`, `mem_wdata`, `out_data` = 0.
- Reset asserted mid-transfer aborts immediately. No partial done is reported.
- Request latency:
  - `rd_en` high at edge E gives `in_ready`=1 in the cycle after E.
  - `wr_en` high at edge E gives `mem_re`=1 in the cycle after E.
- Load throughput is 1 word/cycle.
  - The last word is accepted at edge E.
  - The last `mem_we` is high in cycle E+1 (LOAD_FLUSH).
  - `rd_done` rises at E+2.
- Unload throughput is at most 1 word per 3 cycles (UNL_RD, UNL_WAIT, UNL_OUT).
  - The first `out_valid` comes 3 cycles after leaving IDLE.
- Done to idle:
  - `rd_en`/`wr_en` is sampled low at edge F; the done flag falls after F.
  - `busy` falls after F.
  - A new request can be taken at F+1 at the earliest.

## Test plan
- Load, no backpressure:
  - Stimulus: WORDS=4, pulse `rd_en` high, stream 0xA0..0xA3 with `in_valid` always high.
  - Required: exactly 4 `mem_we` strobes at addr 0..3 with matching data; `rd_done` high 2 cycles after the last acceptance; IDLE one edge after `rd_en` falls.
- Unload with backpressure:
  - Stimulus: memory preloaded 0x10..0x13; raise `wr_en`; toggle `out_ready` 1-0-1.
  - Required: `out_data` sequence 0x10,0x11,0x12,0x13; data held stable while `out_ready`=0; `wr_done` after the 4th handshake.
- Simultaneous requests:
  - Stimulus: `rd_en`=`wr_en`=1 in IDLE.
  - Required: LOAD runs and `wr_done` stays 0; after `rd_en`/`rd_done` clear with `wr_en` still high, UNL_RD is entered.
- Gapped input:
  - Stimulus: `in_valid` low for 5 cycles between words 1 and 2.
  - Required: no `mem_we` during the gap; addresses stay contiguous.
- Reset mid-load:
  - Stimulus: assert `reset`=0 after 2 of 4 words.
  - Required: all outputs 0 immediately; a subsequent full load writes starting at addr 0.
- Full address space:
  - Stimulus: ADDR_W=2, WORDS=4.
  - Required: last address 3, completion is correct, and no counter overflow is visible on `mem_addr`.
